// File: rtl/apb_slv_pkg.sv
// Shared types and helpers for the APB memory completer.
package apb_slv_pkg;

  // Bus phase as seen by the completer; SETUP is decoded from the bus while idle.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_slv_state_e;

  localparam int WAIT_CNT_W = 4;
  typedef logic [WAIT_CNT_W-1:0] wait_cnt_t;

  // Address is in error when it is not word aligned or its word index lies past the memory.
  function automatic logic addr_err(input logic [63:0] addr, input int unsigned depth,
                                    input int unsigned lsb);
    logic misaligned;
    logic out_of_range;
    misaligned   = (addr & ((64'd1 << lsb) - 64'd1)) != 64'd0;
    out_of_range = (addr >> lsb) >= 64'(depth);
    return misaligned || out_of_range;
  endfunction

endpackage

// File: rtl/apb_slv_regfile.sv
// Word-organised register file with byte-enable write port and registered read port.
module apb_slv_regfile #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int AW     = 4
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_idx,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic [DATA_W/8-1:0] wr_be,
  input  logic                rd_en,
  input  logic                rd_zero,
  input  logic [AW-1:0]       rd_idx,
  output logic [DATA_W-1:0]   rd_data
);

  localparam int NB = DATA_W / 8;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic [DATA_W-1:0] rdata_d;

  // Next memory contents: merge enabled bytes of the write word into the addressed entry.
  always_comb begin
    mem_d = mem_q;
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        mem_d[wr_idx][8*b +: 8] = wr_be[b] ? wr_data[8*b +: 8] : mem_q[wr_idx][8*b +: 8];
      end
    end else begin
      mem_d = mem_q;
    end
  end

  // Read data register: loads on a read request, forced to zero for errored reads, else holds.
  always_comb begin
    rdata_d = rdata_q;
    if (rd_en) begin
      rdata_d = rd_zero ? {DATA_W{1'b0}} : mem_q[rd_idx];
    end else begin
      rdata_d = rdata_q;
    end
  end

  // Storage and read register with asynchronous clear.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= {DATA_W{1'b0}};
      end
      rdata_q <= {DATA_W{1'b0}};
    end else begin
      mem_q   <= mem_d;
      rdata_q <= rdata_d;
    end
  end

  assign rd_data = rdata_q;

endmodule

// File: rtl/apb_mem_slave.sv
// APB3/APB4 completer backed by a register-file memory, with wait states,
// address error responses and abort detection.
// Optional byte strobes: define APB_SLV_PSTRB_EN to add the PSTRB port.
module apb_mem_slave
  import apb_slv_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 16,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                CLK,
  input  logic                Rst,
  input  logic                PSEL,
  input  logic                PENABLE,
  input  logic                PWRITE,
  input  logic [ADDR_W-1:0]   PADDR,
  input  logic [DATA_W-1:0]   PWDATA,
`ifdef APB_SLV_PSTRB_EN
  input  logic [DATA_W/8-1:0] PSTRB,
`endif
  output logic [DATA_W-1:0]   PRDATA,
  output logic                PREADY,
  output logic                PSLVERR,
  output logic                prot_abort
);

  localparam int NB     = DATA_W / 8;
  localparam int LSB    = $clog2(NB);
  localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  apb_slv_state_e    state_q, state_d, phase_s;
  wait_cnt_t         wait_cnt_q, wait_cnt_d;
  logic [MEM_AW-1:0] addr_q, addr_d;
  logic              write_q, write_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [NB-1:0]     strb_q, strb_d;
  logic              err_q, err_d;
  logic              prot_abort_q, prot_abort_d;

  logic [MEM_AW-1:0] setup_idx_s;
  logic [NB-1:0]     setup_strb_s;
  logic              setup_err_s;
  logic              pready_s;
  logic              mem_we_s, mem_re_s, rd_zero_s;

  assign setup_idx_s = MEM_AW'(PADDR >> LSB);

`ifdef APB_SLV_PSTRB_EN
  assign setup_strb_s = PSTRB;
  assign setup_err_s  = addr_err(64'(PADDR), DEPTH, LSB) || (!PWRITE && (PSTRB != {NB{1'b0}}));
`else
  assign setup_strb_s = {NB{1'b1}};
  assign setup_err_s  = addr_err(64'(PADDR), DEPTH, LSB);
`endif

  assign pready_s = (state_q == ACCESS) && (wait_cnt_q == wait_cnt_t'(WAIT_CYCLES));

  // Current phase: a registered ACCESS, or a setup cycle decoded from the bus while idle.
  always_comb begin
    phase_s = IDLE;
    if (state_q == ACCESS) begin
      phase_s = ACCESS;
    end else if (PSEL && !PENABLE) begin
      phase_s = SETUP;
    end else begin
      phase_s = IDLE;
    end
  end

  // Transfer sequencing: latch on setup, stall/complete/abort in access.
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    addr_d       = addr_q;
    write_d      = write_q;
    wdata_d      = wdata_q;
    strb_d       = strb_q;
    err_d        = err_q;
    prot_abort_d = 1'b0;
    mem_we_s     = 1'b0;
    mem_re_s     = 1'b0;
    rd_zero_s    = 1'b0;
    case (phase_s)
      SETUP: begin
        addr_d     = setup_idx_s;
        write_d    = PWRITE;
        wdata_d    = PWDATA;
        strb_d     = setup_strb_s;
        err_d      = setup_err_s;
        wait_cnt_d = '0;
        state_d    = ACCESS;
        // Read data is fetched on the setup edge so it is ready in the first access cycle.
        mem_re_s   = !PWRITE;
        rd_zero_s  = setup_err_s;
      end
      ACCESS: begin
        if (PSEL && PENABLE) begin
          if (pready_s) begin
            state_d  = IDLE;
            mem_we_s = write_q && !err_q;
          end else begin
            wait_cnt_d = wait_cnt_q + wait_cnt_t'(1);
          end
        end else begin
          // Master left the transfer before completion: drop it without side effects.
          state_d      = IDLE;
          prot_abort_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and latched-transfer registers.
  always_ff @(posedge CLK or posedge Rst) begin
    if (Rst) begin
      state_q      <= IDLE;
      wait_cnt_q   <= '0;
      addr_q       <= '0;
      write_q      <= 1'b0;
      wdata_q      <= '0;
      strb_q       <= '0;
      err_q        <= 1'b0;
      prot_abort_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      addr_q       <= addr_d;
      write_q      <= write_d;
      wdata_q      <= wdata_d;
      strb_q       <= strb_d;
      err_q        <= err_d;
      prot_abort_q <= prot_abort_d;
    end
  end

  apb_slv_regfile #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .AW    (MEM_AW)
  ) u_regfile (
    .CLK    (CLK),
    .Rst    (Rst),
    .wr_en  (mem_we_s),
    .wr_idx (addr_q),
    .wr_data(wdata_q),
    .wr_be  (strb_q),
    .rd_en  (mem_re_s),
    .rd_zero(rd_zero_s),
    .rd_idx (setup_idx_s),
    .rd_data(PRDATA)
  );

  assign PREADY     = pready_s;
  assign PSLVERR    = pready_s && err_q;
  assign prot_abort = prot_abort_q;

endmodule
